router_pkt_tx: RTL and testbench

Packet transmitter that drives the router's input port, the source side of the byte protocol the router input register accepts. Upstream loads a payload into an internal buffer, then issues `start` with a destination. The block then sends a header byte, the payload bytes and an even-XOR parity byte, stalling while the router asserts `busy`. After the packet it samples the router's `err` to report per-packet parity status.

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_tx_buf.sv | 70 +++++++
 rtl/router_pkt_tx.sv | 207 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter.
// Holds the transmitter state enum, the header byte layout
// (addr in [1:0], len in [7:2]) and the reserved destination address.
package router_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;

  // Destination 3 does not exist on the router.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_PAR,
    ST_GAP
  } tx_state_e;

  // Header byte: len occupies [7:2], addr occupies [1:0].
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } router_hdr_t;

  function automatic logic [BYTE_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    router_hdr_t hdr;
    hdr.len  = len;
    hdr.addr = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for the packet transmitter.
// DEPTH x 8 register array filled in order from index 0, with an
// indexed combinational read port.
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   clr_i          - discard contents (count back to zero)
//   wr_en_i        - append wr_data_i (ignored while full)
//   wr_data_i      - byte to append
//   rd_idx_i       - read index
//   rd_data_o      - byte at rd_idx_i (zero when out of range)
//   cnt_o          - number of stored bytes
//   full_o         - registered, high when cnt_o == DEPTH
module router_tx_buf
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_idx_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic [LEN_W-1:0]  cnt_o,
  output logic              full_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              wr_ok_c;

  assign wr_ok_c = wr_en_i && !full_q;

  // Count / full next state; clear wins over a write.
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (wr_ok_c) begin
      cnt_d  = cnt_q + LEN_W'(1);
      full_d = (cnt_q == LEN_W'(DEPTH - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Storage needs no reset: the count defines which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_ok_c && !clr_i) begin
      mem_q[cnt_q] <= wr_data_i;
    end
  end

  assign rd_data_o = (32'(rd_idx_i) < DEPTH) ? mem_q[rd_idx_i] : '0;
  assign cnt_o     = cnt_q;
  assign full_o    = full_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: sends header, buffered payload and an
// even-XOR parity byte to the router input port, stalling on busy, then
// waits GAP_CYCLES cycles while collecting the router's err flag.
// Optional feature macro: ROUTER_TX_PARITY_CORRUPT_EN adds input corrupt,
// sampled with an accepted start, which inverts parity bit 0.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   wr_en, wr_data        - payload buffer write (IDLE only)
//   wr_full               - buffer holds DEPTH bytes
//   start, dest_addr      - send request and destination (0..2)
//   corrupt               - (macro only) corrupt parity of this packet
//   busy                  - router stall
//   err_in                - router parity-error flag
//   data_out, pkt_valid   - byte stream to router
//   tx_active             - packet in progress
//   done                  - pulse at end of the gap
//   pkt_err               - error status of last packet
//   start_rej             - pulse when start is refused
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned DEPTH      = 63,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  input  logic              corrupt,
`endif
  input  logic              busy,
  input  logic              err_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_active,
  output logic              done,
  output logic              pkt_err,
  output logic              start_rej
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] par_q, par_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              pvld_q, pvld_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rej_q, rej_d;
  logic              corrupt_q;

  logic              wr_ok_c;
  logic [LEN_W-1:0]  cnt_post_c;
  logic              start_ok_c;
  logic              clr_c;
  logic [LEN_W-1:0]  rd_idx_c;
  logic [BYTE_W-1:0] buf_rdata;
  logic [LEN_W-1:0]  buf_cnt;
  logic              buf_full;

  router_tx_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (clr_c),
    .wr_en_i   (wr_ok_c),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx_c),
    .rd_data_o (buf_rdata),
    .cnt_o     (buf_cnt),
    .full_o    (buf_full)
  );

  // A same-cycle write lands before start, so the header length uses
  // the post-write count.
  assign wr_ok_c    = wr_en && (state_q == ST_IDLE) && !buf_full;
  assign cnt_post_c = buf_cnt + LEN_W'(wr_ok_c);
  assign start_ok_c = (state_q == ST_IDLE) && start && (cnt_post_c != '0)
                      && (dest_addr != ADDR_INVALID);

  // Prefetch the byte that goes on the wire after the current transfer.
  assign rd_idx_c = (state_q == ST_HDR) ? '0 : idx_q + LEN_W'(1);

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      corrupt_q <= 1'b0;
    end else if (start_ok_c) begin
      corrupt_q <= corrupt;
    end
  end
`else
  assign corrupt_q = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    par_d   = par_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    pvld_d  = pvld_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    err_d   = err_q;
    clr_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          state_d = ST_HDR;
          dout_d  = make_hdr(cnt_post_c, dest_addr);
          pvld_d  = 1'b1;
          err_d   = 1'b0;
        end else if (start) begin
          rej_d = 1'b1;
        end
      end
      ST_HDR: begin
        if (!busy) begin
          state_d = ST_PLD;
          par_d   = dout_q;
          idx_d   = '0;
          dout_d  = buf_rdata;
        end
      end
      ST_PLD: begin
        if (!busy) begin
          par_d = par_q ^ dout_q;
          idx_d = idx_q + LEN_W'(1);
          if ((idx_q + LEN_W'(1)) == buf_cnt) begin
            state_d = ST_PAR;
            dout_d  = par_q ^ dout_q ^ BYTE_W'(corrupt_q);
            pvld_d  = 1'b0;
          end else begin
            dout_d = buf_rdata;
          end
        end
      end
      ST_PAR: begin
        if (!busy) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        err_d = err_q | err_in;
        if (gap_q == GAP_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          clr_c   = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      par_q    <= '0;
      gap_q    <= '0;
      dout_q   <= '0;
      pvld_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      gap_q    <= gap_d;
      dout_q   <= dout_d;
      pvld_q   <= pvld_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rej_q    <= rej_d;
    end
  end

  assign data_out  = dout_q;
  assign pkt_valid = pvld_q;
  assign tx_active = active_q;
  assign done      = done_q;
  assign pkt_err   = err_q;
  assign start_rej = rej_q;
  assign wr_full   = buf_full;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: packet-level model compared every cycle,
// plus literal expectations on the transmitted byte sequences.
`timescale 1ns/1ps
module tb_router_pkt_tx;

  localparam int DEPTH = 63;
  localparam int GAP   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_full;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic       busy = 1'b0;
  logic       err_in = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid, tx_active, done, pkt_err, start_rej;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic       corrupt = 1'b0;
`endif

  router_pkt_tx #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .start     (start),
    .dest_addr (dest_addr),
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    .corrupt   (corrupt),
`endif
    .busy      (busy),
    .err_in    (err_in),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_active (tx_active),
    .done      (done),
    .pkt_err   (pkt_err),
    .start_rej (start_rej)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Packet-level model: payload queue, pending wire bytes, gap position.
  logic [7:0] m_buf[$];
  logic [8:0] m_send[$];   // {pkt_valid, byte}
  logic [8:0] captured[$]; // bytes that actually transferred
  logic [7:0] m_hold = 8'h00;
  int         m_gap  = 0;  // cycles since parity transfer, 0 when not in a gap
  logic       m_err  = 1'b0;
  logic       m_rej  = 1'b0;
  logic       m_full = 1'b0;

  always @(negedge clock) begin
    logic [7:0] ed, p, h;
    logic       ev, ea;
    logic [8:0] b;
    if (m_send.size() > 0) begin
      ed = m_send[0][7:0];
      ev = m_send[0][8];
      ea = 1'b1;
    end else begin
      ed = m_hold;
      ev = 1'b0;
      ea = (m_gap >= 1) && (m_gap <= GAP);
    end
    chk("data_out",  32'(data_out),  32'(ed));
    chk("pkt_valid", 32'(pkt_valid), 32'(ev));
    chk("tx_active", 32'(tx_active), 32'(ea));
    chk("done",      32'(done),      32'(m_gap == GAP + 1));
    chk("start_rej", 32'(start_rej), 32'(m_rej));
    chk("pkt_err",   32'(pkt_err),   32'(m_err));
    chk("wr_full",   32'(wr_full),   32'(m_full));

    // Advance the model to what the next edge produces.
    m_rej = 1'b0;
    if (reset) begin
      m_buf.delete();
      m_send.delete();
      m_hold = 8'h00;
      m_gap  = 0;
      m_err  = 1'b0;
      m_full = 1'b0;
    end else if (m_send.size() > 0) begin
      if (!busy) begin
        b = m_send.pop_front();
        captured.push_back(b);
        m_hold = b[7:0];
        if (m_send.size() == 0) m_gap = 1;
      end
    end else if (m_gap >= 1 && m_gap <= GAP) begin
      m_err = m_err | err_in;
      m_gap++;
      if (m_gap == GAP + 1) begin
        m_buf.delete();
        m_full = 1'b0;
      end
    end else begin
      m_gap = 0;
      if (wr_en && m_buf.size() < DEPTH) m_buf.push_back(wr_data);
      m_full = (m_buf.size() == DEPTH);
      if (start) begin
        if (m_buf.size() >= 1 && dest_addr != 2'b11) begin
          h = {6'(m_buf.size()), dest_addr};
          p = h;
          m_send.push_back({1'b1, h});
          foreach (m_buf[i]) begin
            m_send.push_back({1'b1, m_buf[i]});
            p = p ^ m_buf[i];
          end
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
          if (corrupt) p[0] = ~p[0];
`endif
          m_send.push_back({1'b0, p});
          m_err = 1'b0;
        end else begin
          m_rej = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] a);
    start = 1'b1;
    dest_addr = a;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Compare the captured transfer sequence against literal bytes.
  task automatic chk_seq(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, 32'(captured.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < captured.size(); i++) begin
      chk({nm, "_byte"},  32'(captured[i][7:0]), 32'(exp[i]));
      chk({nm, "_valid"}, 32'(captured[i][8]),   32'(i < exp.size() - 1));
    end
  endtask

  initial begin
    int n;
    logic [7:0] exp_q[$];

    // Reset
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_wr_full", 32'(wr_full), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);

    // Basic packet AA,55,0F to port 1
    captured.delete();
    wr(8'hAA); wr(8'h55); wr(8'h0F);
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    corrupt = 1'b1;
`endif
    go(2'd1);
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    corrupt = 1'b0;
`endif
    chk("p1_header", 32'(data_out), 32'h0D);
    wait_done(n);
    chk("p1_latency", 32'(n), 32'd8);
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h0F, 8'hFC};
`else
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h0F, 8'hFD};
`endif
    chk_seq("p1", exp_q);

    // Same packet, busy for 4 cycles while 55 is on the wire
    captured.delete();
    wr(8'hAA); wr(8'h55); wr(8'h0F);
    go(2'd1);
    cyc();
    cyc();
    chk("p2_byte1", 32'(data_out), 32'h55);
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p2_busy_hold", 32'(data_out), 32'h55);
    end
    busy = 1'b0;
    wait_done(n);
    exp_q = '{8'h0D, 8'hAA, 8'h55, 8'h0F, 8'hFD};
    chk_seq("p2", exp_q);

    // Rejections: empty buffer, then invalid address
    go(2'd0);
    chk("rej_empty", 32'(start_rej), 32'd1);
    chk("rej_empty_active", 32'(tx_active), 32'd0);
    cyc();
    chk("rej_pulse_end", 32'(start_rej), 32'd0);
    wr(8'h11);
    go(2'd3);
    chk("rej_addr3", 32'(start_rej), 32'd1);
    chk("rej_addr3_active", 32'(tx_active), 32'd0);
    go(2'd0);
    chk("after_rej_header", 32'(data_out), 32'h04);
    wait_done(n);

    // Write and start in the same cycle on an empty buffer
    captured.delete();
    wr_en = 1'b1; wr_data = 8'h3C; start = 1'b1; dest_addr = 2'd2;
    cyc();
    wr_en = 1'b0; start = 1'b0;
    chk("wr_start_header", 32'(data_out), 32'h06);
    wait_done(n);
    exp_q = '{8'h06, 8'h3C, 8'h3A};
    chk_seq("wrst", exp_q);

    // Full buffer: 63 bytes, one extra dropped
    captured.delete();
    for (int i = 1; i <= DEPTH; i++) wr(8'(i));
    chk("full_set", 32'(wr_full), 32'd1);
    wr(8'hEE);
    chk("full_hold", 32'(wr_full), 32'd1);
    go(2'd1);
    chk("full_header", 32'(data_out), 32'hFD);
    wait_done(n);
    chk("full_len", 32'(captured.size()), 32'd65);
    if (captured.size() == 65) begin
      chk("full_last_pld", 32'(captured[63][7:0]), 32'h3F);
      chk("full_parity", 32'(captured[64][7:0]), 32'hFD);
    end
    chk("full_cleared", 32'(wr_full), 32'd0);

    // err_in during the gap
    wr(8'h21); wr(8'h42);
    go(2'd0);
    for (int i = 0; i < 50; i++) begin
      if (!pkt_valid && tx_active) break;
      cyc();
    end
    cyc();
    err_in = 1'b1;
    cyc();
    err_in = 1'b0;
    wait_done(n);
    chk("err_set", 32'(pkt_err), 32'd1);
    cyc(); cyc(); cyc();
    chk("err_held", 32'(pkt_err), 32'd1);
    go(2'd3);
    chk("err_held_rej", 32'(pkt_err), 32'd1);
    wr(8'h01);
    go(2'd0);
    chk("err_cleared", 32'(pkt_err), 32'd0);
    wait_done(n);

    // Reset during payload
    wr(8'h10); wr(8'h20); wr(8'h30); wr(8'h40); wr(8'h50);
    go(2'd2);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_data", 32'(data_out), 32'h00);
    chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
    chk("mid_rst_active", 32'(tx_active), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(pkt_err), 32'd0);
    chk("mid_rst_rej", 32'(start_rej), 32'd0);
    chk("mid_rst_full", 32'(wr_full), 32'd0);
    go(2'd0);
    chk("mid_rst_cnt0", 32'(start_rej), 32'd1);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
